alu_share_ctrl: RTL and testbench
=================================

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter WIDTH, default 64: operand/result width; matches the 64-bit ALU datapath.
REQ-002 Parameter EXEC_CYCLES, default 1: ALU settle cycles per operation; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0_valid / req1_valid  input  1 each  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1 each  operation of requester n accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-008 req0_cin, req1_cin  input  1 each  carry-in.
REQ-009 req0_op, req1_op  input  2 each  ALU opcode, passed through unmodified.
REQ-010 alu_a, alu_b  output  WIDTH  operands to the shared ALU.
REQ-011 alu_cin  output  1  and alu_op  output  2  to the shared ALU.
REQ-012 alu_s  input  WIDTH  and alu_cout  input  1  ALU result.
REQ-013 rsp_valid  output  1  response held.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_id  output  1  requester index (0/1) owning the response.
REQ-016 rsp_s  output  WIDTH  and rsp_cout  output  1  captured result.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, RESP.
REQ-019 IDLE: grant at most one requester; reqN_ready is combinational, high only for the granted requester while in IDLE.
REQ-020 Arbitration: round-robin; pointer prio initially 0; if both valid, grant = prio; if one valid, grant it regardless of prio.
REQ-021 On grant: capture a, b, cin, op and the grant id into internal registers; next state EXEC.
REQ-022 alu_a/alu_b/alu_cin/alu_op are driven only from the captured registers, never combinationally from request inputs; they hold their values in all states.
REQ-023 EXEC: lasts exactly EXEC_CYCLES cycles, counted by a 4-bit down-counter; on the last EXEC cycle, capture alu_s/alu_cout into rsp_s/rsp_cout; next state RESP.
REQ-024 RESP: rsp_valid=1; rsp_id, rsp_s and rsp_cout stable until the handshake.
REQ-025 RESP with rsp_ready=1: handshake completes; prio <= ~grant_id; next state IDLE.
REQ-026 No new grant in EXEC or RESP; both reqN_ready low.
REQ-027 Latency: accept at cycle N -> rsp_valid first high at cycle N+1+EXEC_CYCLES.
REQ-028 Throughput: with rsp_ready tied high, one operation per EXEC_CYCLES+2 cycles.
REQ-029 Requests that drop valid before a grant are not remembered.
REQ-030 rsp_ready in IDLE or EXEC is ignored.

Reset
REQ-031 While rst=1: state=IDLE, prio=0, counter=0, busy=0, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_cout=0, alu_a=0, alu_b=0, alu_cin=0, alu_op=0, reqN_ready=0.
REQ-032 rst asserted mid-EXEC or mid-RESP aborts the operation; no response is produced after release.
REQ-033 The first grant is possible in the first clock edge after rst deasserts.

Configuration
REQ-034 Macro ALU_SHARE_PERF_EN: when defined, adds outputs gnt0_cnt and gnt1_cnt (16 bits each); each counts completed responses per requester, wraps 0xFFFF->0, and resets to 0.
REQ-035 Without ALU_SHARE_PERF_EN: those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-036 Reset, then req0 only: a=0, b=all-ones, cin=0, op=2'b10, EXEC_CYCLES=1 -> req0_ready high at cycle N, rsp_valid at N+2 with rsp_id=0 and rsp_s/rsp_cout equal to the ALU output for those operands.
REQ-037 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-038 rsp_ready held low 10 cycles in RESP -> rsp_valid stays high and rsp_s stays constant; no reqN_ready pulse; after release, IDLE on the next cycle.
REQ-039 EXEC_CYCLES=15 -> rsp_valid 16 cycles after the accept; operands change on req inputs during EXEC with no effect on alu_a/alu_b.
REQ-040 rst pulsed during EXEC -> all outputs return to reset values immediately; no rsp_valid follows.
REQ-041 With ALU_SHARE_PERF_EN, 65537 req1 operations -> gnt1_cnt=1, gnt0_cnt=0.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
// Two-requester front end for a single shared ALU. The controller grants one
// operation at a time using round-robin arbitration. It holds the captured
// operands on the ALU for EXEC_CYCLES cycles, then keeps the result until the
// consumer accepts it.
//
// Parameters
//   WIDTH        operand/result width (default 64)
//   EXEC_CYCLES  ALU settle cycles per operation, 1..15 (default 1)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     request handshake, N = 0/1 (ready is
//                               combinational, IDLE only)
//   reqN_a, reqN_b, reqN_cin,
//   reqN_op                     request operands
//   alu_a, alu_b, alu_cin,
//   alu_op                      registered operands to the shared ALU
//   alu_s, alu_cout             ALU result
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_s, rsp_cout     owning requester and captured result
//   busy                        controller not in IDLE
//   gnt0_cnt, gnt1_cnt          completed responses per requester, 16-bit
//                               wrapping; present only when the macro
//                               ALU_SHARE_PERF_EN is defined
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int WIDTH       = 64,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout,
    output logic             busy
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [15:0]      gnt0_cnt,
    output logic [15:0]      gnt1_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // The counter starts at EXEC_CYCLES-1 so that the cycle on which it
    // reads zero is the last EXEC cycle.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    logic [1:0] state;
    logic       prio;
    logic [3:0] cnt;
    logic       gid;
    logic       gnt_any;
    logic       gnt_sel;

    // Arbitration only happens in IDLE. The rst term keeps both ready
    // outputs low while reset is held, even though state already reads IDLE.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                gnt_any = 1'b1;
                gnt_sel = prio;
            end else if (req0_valid) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (req1_valid) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_any && !gnt_sel;
    assign req1_ready = gnt_any &&  gnt_sel;
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = gid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            cnt      <= '0;
            gid      <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_cin  <= 1'b0;
            alu_op   <= 2'b00;
            rsp_s    <= '0;
            rsp_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gid     <= gnt_sel;
                        alu_a   <= gnt_sel ? req1_a   : req0_a;
                        alu_b   <= gnt_sel ? req1_b   : req0_b;
                        alu_cin <= gnt_sel ? req1_cin : req0_cin;
                        alu_op  <= gnt_sel ? req1_op  : req0_op;
                        cnt     <= CNT_LOAD;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_s    <= alu_s;
                        rsp_cout <= alu_cout;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        prio  <= ~gid;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else if (state == RESP && rsp_ready) begin
            if (gid) gnt1_cnt <= gnt1_cnt + 16'd1;
            else     gnt0_cnt <= gnt0_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
// Directed bench for alu_share_ctrl. Two instances share the request inputs:
// u_dut1 uses EXEC_CYCLES=1 and u_dut15 uses EXEC_CYCLES=15. Each instance
// drives its own behavioural ALU.
// ALU model: op 00 a+b+cin, 01 a+~b+cin, 10 a^b, 11 a&b (cout 0 for logic ops).
// ----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_cin, req1_cin, rsp_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;

    logic         r0_1, r1_1, acin_1, acout_1, rv_1, rid_1, rc_1, busy_1;
    logic [W-1:0] aa_1, ab_1, as_1, rs_1;
    logic [1:0]   aop_1;
    logic         r0_15, r1_15, acin_15, acout_15, rv_15, rid_15, rc_15, busy_15;
    logic [W-1:0] aa_15, ab_15, as_15, rs_15;
    logic [1:0]   aop_15;
`ifdef ALU_SHARE_PERF_EN
    logic [15:0]  g0_1, g1_1, g0_15, g1_15;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
            2'b10:   return {1'b0, a ^ b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    assign {acout_1, as_1}   = alu_model(aa_1, ab_1, acin_1, aop_1);
    assign {acout_15, as_15} = alu_model(aa_15, ab_15, acin_15, aop_15);

    alu_share_ctrl #(.WIDTH(W), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_1), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(r1_1), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_op(req1_op),
        .alu_a(aa_1), .alu_b(ab_1), .alu_cin(acin_1), .alu_op(aop_1),
        .alu_s(as_1), .alu_cout(acout_1),
        .rsp_valid(rv_1), .rsp_ready(rsp_ready), .rsp_id(rid_1), .rsp_s(rs_1),
        .rsp_cout(rc_1), .busy(busy_1)
`ifdef ALU_SHARE_PERF_EN
        , .gnt0_cnt(g0_1), .gnt1_cnt(g1_1)
`endif
    );

    alu_share_ctrl #(.WIDTH(W), .EXEC_CYCLES(15)) u_dut15 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_15), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(r1_15), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_op(req1_op),
        .alu_a(aa_15), .alu_b(ab_15), .alu_cin(acin_15), .alu_op(aop_15),
        .alu_s(as_15), .alu_cout(acout_15),
        .rsp_valid(rv_15), .rsp_ready(rsp_ready), .rsp_id(rid_15), .rsp_s(rs_15),
        .rsp_cout(rc_15), .busy(busy_15)
`ifdef ALU_SHARE_PERF_EN
        , .gnt0_cnt(g0_15), .gnt1_cnt(g1_15)
`endif
    );

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [W-1:0] held_s;
        logic         exp_id;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_op = 2'b00;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_op = 2'b00;
        tick();
        tick();

        // Reset values, with a request already pending.
        req0_valid = 1'b1; req0_a = '0; req0_b = ONES; req0_cin = 1'b0; req0_op = 2'b10;
        #1;
        check("rst_ready0", W'(r0_1), '0);
        check("rst_busy", W'(busy_1), '0);
        check("rst_rsp_valid", W'(rv_1), '0);
        check("rst_alu_a", {1'b0, aa_1}, '0);
        check("rst_rsp", {rc_1, rs_1}, '0);

        // First grant right after reset release; response two cycles later.
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("acc_ready0", {W'(r1_1), r0_1}, 65'd1);
        tick();
        req0_valid = 1'b0;
        check("exec_busy", {W'(rv_1), busy_1}, 65'd1);
        check("exec_alu_b", {1'b0, ab_1}, {1'b0, ONES});
        check("exec_alu_op", W'(aop_1), 65'd2);
        tick();
        check("resp_valid", W'(rv_1), 65'd1);
        check("resp_id", W'(rid_1), 65'd0);
        check("resp_res", {rc_1, rs_1}, {1'b0, ONES});

        // Stall in RESP for 10 cycles with both requesters pending.
        held_s = rs_1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", W'(rv_1), 65'd1);
            check("hold_s", {1'b0, rs_1}, {1'b0, held_s});
            check("hold_ready", {W'(r1_1), r0_1}, 65'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("rel_idle", {W'(busy_1), rv_1}, 65'd0);
        // prio flipped to 1 after requester 0's response.
        check("rel_grant1", {W'(r1_1), r0_1}, 65'd2);

        // Alternating arbitration from reset.
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        do_reset();
        req0_a = 64'd5; req0_b = 64'd3; req0_cin = 1'b1; req0_op = 2'b00;
        req1_a = ONES;  req1_b = 64'd1; req1_cin = 1'b0; req1_op = 2'b00;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            check("rr_ready", {W'(r1_1), r0_1}, exp_id ? 65'd2 : 65'd1);
            tick();
            tick();
            check("rr_valid", W'(rv_1), 65'd1);
            check("rr_id", W'(rid_1), W'(exp_id));
            // 5+3+1 = 9 ; ones+1 = 0 carry 1
            check("rr_res", {rc_1, rs_1}, exp_id ? {1'b1, 64'd0} : 65'd9);
            tick();
        end

        // Reset pulse during EXEC aborts the operation.
        req1_valid = 1'b0;
        req0_a = 64'h1234; req0_b = 64'h0F0F; req0_op = 2'b11;
        do_reset();
        check("ab_ready", W'(r0_1), 65'd1);
        tick();
        check("ab_exec", W'(busy_1), 65'd1);
        rst = 1'b1;
        #1;
        check("ab_busy", {W'(rv_1), busy_1}, 65'd0);
        check("ab_alu", {aop_1, aa_1[62:0]}, '0);
        check("ab_ready_rst", W'(r0_1), 65'd0);
        req0_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ab_no_rsp", {W'(busy_1), rv_1}, 65'd0);
        end

        // EXEC_CYCLES=15: response 16 cycles after accept, ALU operands hold.
        do_reset();
        req0_a = 64'd10; req0_b = 64'd20; req0_cin = 1'b0; req0_op = 2'b00;
        req0_valid = 1'b1; rsp_ready = 1'b0;
        #1;
        check("e15_ready", W'(r0_15), 65'd1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            req0_valid = 1'b0;
            req0_a = 64'(700 + i); req0_b = 64'(900 + i);
            check("e15_wait", W'(rv_15), 65'd0);
            check("e15_alu_a", {1'b0, aa_15}, 65'd10);
            check("e15_alu_b", {1'b0, ab_15}, 65'd20);
        end
        tick();
        check("e15_valid", W'(rv_15), 65'd1);
        check("e15_res", {rc_15, rs_15}, 65'd30);
        rsp_ready = 1'b1;
        tick();
        check("e15_idle", W'(busy_15), 65'd0);
`ifdef ALU_SHARE_PERF_EN
        check("perf_g0", W'(g0_15), 65'd1);
        check("perf_g1", W'(g1_15), 65'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
